// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: access sizes, exception codes,
// sequencer states and the byte-lane masks of a naturally aligned access.
package aura_mem_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_BYTE    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } AccessSize;

    typedef enum logic [1:0] {
        EXC_NONE  = 2'b00,
        EXC_BUS   = 2'b01,
        EXC_USAGE = 2'b10
    } ExcCode;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BEAT0 = 2'b01,
        ST_BEAT1 = 2'b10
    } SeqState;

    localparam logic [3:0] LANES_WORD = 4'b1111;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_NONE = 4'b0000;

    // Lane mask of an access at offset 0; shifted by the byte offset later.
    function automatic logic [3:0] baseLanes(input AccessSize size);
        case (size)
            SIZE_WORD: baseLanes = LANES_WORD;
            SIZE_HALF: baseLanes = LANES_HALF;
            SIZE_BYTE: baseLanes = LANES_BYTE;
            default:   baseLanes = LANES_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_aligner.sv
// Combinational load aligner: merges the two read beats of a (possibly split)
// access, shifts the addressed bytes down, masks to size and extends.
// For a single-beat access loWord and hiWord carry the same bus word; the
// bytes taken from hiWord are then always discarded by the size mask.
module mem_load_aligner
    import aura_mem_pkg::*;
(
    input  logic [31:0] loWord,
    input  logic [31:0] hiWord,
    input  logic [1:0]  offset,
    input  AccessSize   size,
    input  logic        signedLoad,
    output logic [31:0] loadData
);

    logic [63:0] beatPair;
    logic [31:0] rawData;

    assign beatPair = {hiWord, loWord};
    assign rawData  = 32'(beatPair >> {offset, 3'b000});

    // Mask to the access size and apply sign or zero extension.
    always_comb begin
        loadData = 32'd0;
        case (size)
            SIZE_WORD: loadData = rawData;
            SIZE_HALF: loadData = signedLoad ? {{16{rawData[15]}}, rawData[15:0]}
                                             : {16'd0, rawData[15:0]};
            SIZE_BYTE: loadData = signedLoad ? {{24{rawData[7]}}, rawData[7:0]}
                                             : {24'd0, rawData[7:0]};
            default:   loadData = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer between execute and writeback.
// Accepts one request per handshake, runs one or two valid/ack bus beats with
// a wait-state timeout, and returns a single tagged response pulse.
// Build option: MISALIGNED_SPLIT_EN -- when defined, misaligned word/half
// accesses are split into two beats instead of raising a usage fault.
module mem_access_sequencer
    import aura_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqSigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [31:0]       reqStoreData,
    input  logic [TAG_W-1:0]  reqLoadTag,
    output logic              busValid,
    output logic              busWrite,
    output logic [ADDR_W-1:0] busAddr,
    output logic [31:0]       busWData,
    output logic [3:0]        busStrobe,
    input  logic              busAck,
    input  logic              busErr,
    input  logic [31:0]       busRData,
    output logic              rspValid,
    output logic [TAG_W-1:0]  rspTag,
    output logic [31:0]       rspData,
    output logic [1:0]        excCode
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    SeqState          state;
    SeqState          stateNext;
    AccessSize        reqSizeE;
    AccessSize        heldSize;
    logic [1:0]       heldOffset;
    logic             heldSigned;
    logic [TAG_W-1:0] heldTag;
    logic [CNT_W-1:0] toCnt;

    logic [3:0]       beat0Lanes;
    logic [31:0]      beat0WData;
    logic             usageFault;
    logic             accept;
    logic             startBeat;
    logic             beatActive;
    logic             busFault;
    logic             timedOut;
    logic             beatAck;
    logic             lastBeat;
    logic             finishOk;
    logic             advance;
    logic [31:0]      alignLo;
    logic [31:0]      alignedData;

    assign reqSizeE   = AccessSize'(reqSize);
    assign reqReady   = (state == ST_IDLE);
    assign accept     = reqValid && reqReady;
    assign startBeat  = accept && !usageFault;
    assign beatActive = (state != ST_IDLE);

`ifdef MISALIGNED_SPLIT_EN
    logic [7:0]  reqLanes;
    logic [63:0] reqLaneData;
    logic        reqSplit;
    logic        splitPending;
    logic [3:0]  beat1Strobe;
    logic [31:0] beat1WData;
    logic [31:0] beat0RData;

    // Lanes and data laid out across two consecutive words; the upper half
    // is non-empty only for accesses that cross a word boundary.
    assign reqLanes    = {4'b0000, baseLanes(reqSizeE)} << reqAddr[1:0];
    assign reqLaneData = {32'd0, reqStoreData} << {reqAddr[1:0], 3'b000};
    assign reqSplit    = |reqLanes[7:4];
    assign usageFault  = (reqSizeE == SIZE_ILLEGAL);
    assign beat0Lanes  = reqLanes[3:0];
    assign beat0WData  = reqLaneData[31:0];
    assign lastBeat    = (state == ST_BEAT1) || !splitPending;
    assign alignLo     = splitPending ? beat0RData : busRData;
`else
    logic misaligned;

    assign misaligned = ((reqSizeE == SIZE_WORD) && (reqAddr[1:0] != 2'b00)) ||
                        ((reqSizeE == SIZE_HALF) && reqAddr[0]);
    assign usageFault = (reqSizeE == SIZE_ILLEGAL) || misaligned;
    assign beat0Lanes = baseLanes(reqSizeE) << reqAddr[1:0];
    assign beat0WData = reqStoreData << {reqAddr[1:0], 3'b000};
    assign lastBeat   = 1'b1;
    assign alignLo    = busRData;
`endif

    // Beat outcome: an error beats a simultaneous ack; timeout only while waiting.
    assign busFault = beatActive && busErr;
    assign timedOut = beatActive && !busErr && !busAck &&
                      (TIMEOUT_CYCLES != 0) && (toCnt == TO_LAST);
    assign beatAck  = beatActive && busAck && !busErr;
    assign finishOk = beatAck && lastBeat;
    assign advance  = beatAck && !lastBeat;

    mem_load_aligner uAligner (
        .loWord     (alignLo),
        .hiWord     (busRData),
        .offset     (heldOffset),
        .size       (heldSize),
        .signedLoad (heldSigned),
        .loadData   (alignedData)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: IDLE -> BEAT0 -> (BEAT1) -> IDLE.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (startBeat) stateNext = ST_BEAT0;
            end
            ST_BEAT0: begin
                if (busFault || timedOut || finishOk) stateNext = ST_IDLE;
                else if (advance)                     stateNext = ST_BEAT1;
            end
            ST_BEAT1: begin
                if (busFault || timedOut || finishOk) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Bus beat registers, timeout counter and the response pulse.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            busValid   <= 1'b0;
            busWrite   <= 1'b0;
            busAddr    <= '0;
            busWData   <= 32'd0;
            busStrobe  <= 4'd0;
            rspValid   <= 1'b0;
            rspTag     <= '0;
            rspData    <= 32'd0;
            excCode    <= EXC_NONE;
            toCnt      <= '0;
            heldSize   <= SIZE_WORD;
            heldOffset <= 2'd0;
            heldSigned <= 1'b0;
            heldTag    <= '0;
`ifdef MISALIGNED_SPLIT_EN
            splitPending <= 1'b0;
            beat1Strobe  <= 4'd0;
            beat1WData   <= 32'd0;
            beat0RData   <= 32'd0;
`endif
        end else begin
            rspValid <= 1'b0;
            if (startBeat) begin
                busValid   <= 1'b1;
                busWrite   <= reqWrite;
                busAddr    <= {reqAddr[ADDR_W-1:2], 2'b00};
                busWData   <= beat0WData;
                busStrobe  <= beat0Lanes;
                toCnt      <= '0;
                heldSize   <= reqSizeE;
                heldOffset <= reqAddr[1:0];
                heldSigned <= reqSigned;
                heldTag    <= reqWrite ? '0 : reqLoadTag;
`ifdef MISALIGNED_SPLIT_EN
                splitPending <= reqSplit;
                beat1Strobe  <= reqLanes[7:4];
                beat1WData   <= reqLaneData[63:32];
`endif
            end else if (accept) begin
                // Usage fault: answered next cycle without touching the bus.
                rspValid <= 1'b1;
                rspTag   <= reqWrite ? '0 : reqLoadTag;
                rspData  <= 32'd0;
                excCode  <= EXC_USAGE;
            end

            if (busFault || timedOut) begin
                busValid <= 1'b0;
                rspValid <= 1'b1;
                rspTag   <= heldTag;
                rspData  <= 32'd0;
                excCode  <= EXC_BUS;
            end else if (finishOk) begin
                busValid <= 1'b0;
                rspValid <= 1'b1;
                rspTag   <= heldTag;
                rspData  <= busWrite ? 32'd0 : alignedData;
                excCode  <= EXC_NONE;
            end else if (advance) begin
`ifdef MISALIGNED_SPLIT_EN
                // Second beat at the next word; the address wraps modulo 2^ADDR_W.
                busAddr    <= busAddr + ADDR_W'(4);
                busWData   <= beat1WData;
                busStrobe  <= beat1Strobe;
                beat0RData <= busRData;
`endif
                toCnt      <= '0;
            end else if (beatActive) begin
                toCnt <= toCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed testbench for mem_access_sequencer (default timeout of 16 cycles).
// Follows MISALIGNED_SPLIT_EN for the misaligned-word case.
module tb_mem_access_sequencer;

    localparam int ADDR_W = 32;
    localparam int TAG_W  = 4;

    logic              clock = 1'b0;
    logic              resetN;
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqStoreData;
    logic [TAG_W-1:0]  reqLoadTag;
    logic              busValid;
    logic              busWrite;
    logic [ADDR_W-1:0] busAddr;
    logic [31:0]       busWData;
    logic [3:0]        busStrobe;
    logic              busAck;
    logic              busErr;
    logic [31:0]       busRData;
    logic              rspValid;
    logic [TAG_W-1:0]  rspTag;
    logic [31:0]       rspData;
    logic [1:0]        excCode;

    int testsRun  = 0;
    int failCount = 0;

    mem_access_sequencer #(
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .TIMEOUT_CYCLES(16)
    ) dut (
        .clock(clock), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
        .reqStoreData(reqStoreData), .reqLoadTag(reqLoadTag),
        .busValid(busValid), .busWrite(busWrite), .busAddr(busAddr),
        .busWData(busWData), .busStrobe(busStrobe), .busAck(busAck),
        .busErr(busErr), .busRData(busRData),
        .rspValid(rspValid), .rspTag(rspTag), .rspData(rspData), .excCode(excCode)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] tag);
        reqValid     = 1'b1;
        reqWrite     = wr;
        reqSize      = sz;
        reqSigned    = sgn;
        reqAddr      = addr;
        reqStoreData = data;
        reqLoadTag   = tag;
        step();
        reqValid = 1'b0;
    endtask

    task automatic ackBeat(input logic [31:0] data);
        busAck   = 1'b1;
        busRData = data;
        step();
        busAck = 1'b0;
    endtask

    initial begin
        resetN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
        reqSigned = 1'b0; reqAddr = '0; reqStoreData = '0; reqLoadTag = '0;
        busAck = 1'b0; busErr = 1'b0; busRData = '0;
        step(); step();

        // Reset state
        check("rst_reqReady", reqReady, 1);
        check("rst_busValid", busValid, 0);
        check("rst_busWrite", busWrite, 0);
        check("rst_busAddr", busAddr, 0);
        check("rst_busWData", busWData, 0);
        check("rst_busStrobe", busStrobe, 0);
        check("rst_rspValid", rspValid, 0);
        check("rst_rspTag", rspTag, 0);
        check("rst_rspData", rspData, 0);
        check("rst_excCode", excCode, 0);
        resetN = 1'b1;
        step();

        // 1: LW 0x100, three wait states, then ack
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 4'd5);
        check("lw_busValid", busValid, 1);
        check("lw_busAddr", busAddr, 32'h100);
        check("lw_busStrobe", busStrobe, 4'b1111);
        check("lw_busWrite", busWrite, 0);
        check("lw_reqReady", reqReady, 0);
        step(); step(); step();
        check("lw_wait_busValid", busValid, 1);
        check("lw_wait_rspValid", rspValid, 0);
        ackBeat(32'hDEADBEEF);
        check("lw_rspValid", rspValid, 1);
        check("lw_rspData", rspData, 32'hDEADBEEF);
        check("lw_excCode", excCode, 0);
        check("lw_rspTag", rspTag, 5);
        check("lw_busValid_done", busValid, 0);
        check("lw_reqReady_done", reqReady, 1);
        step();
        check("lw_rsp_pulse", rspValid, 0);

        // 2: LB signed / unsigned at 0x103
        issue(1'b0, 2'b10, 1'b1, 32'h103, 32'h0, 4'd3);
        check("lbs_busAddr", busAddr, 32'h100);
        check("lbs_busStrobe", busStrobe, 4'b1000);
        ackBeat(32'h80000000);
        check("lbs_rspData", rspData, 32'hFFFFFF80);
        check("lbs_rspTag", rspTag, 3);
        issue(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 4'd4);
        check("lbu_busStrobe", busStrobe, 4'b1000);
        ackBeat(32'h80000000);
        check("lbu_rspData", rspData, 32'h00000080);

        // 3: SH 0x102 data 0x1234
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234, 4'd7);
        check("sh_busWData", busWData, 32'h12340000);
        check("sh_busStrobe", busStrobe, 4'b1100);
        check("sh_busWrite", busWrite, 1);
        check("sh_busAddr", busAddr, 32'h100);
        ackBeat(32'hFFFFFFFF);
        check("sh_rspValid", rspValid, 1);
        check("sh_rspTag", rspTag, 0);
        check("sh_rspData", rspData, 0);
        check("sh_excCode", excCode, 0);

        // 4: LW 0x101 (misaligned word)
`ifdef MISALIGNED_SPLIT_EN
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 4'd6);
        check("mis_b0_busAddr", busAddr, 32'h100);
        check("mis_b0_busStrobe", busStrobe, 4'b1110);
        ackBeat(32'h332211AA);
        check("mis_b1_busValid", busValid, 1);
        check("mis_b1_busAddr", busAddr, 32'h104);
        check("mis_b1_busStrobe", busStrobe, 4'b0001);
        check("mis_b1_rspValid", rspValid, 0);
        ackBeat(32'hBBCCDD44);
        check("mis_rspValid", rspValid, 1);
        check("mis_rspData", rspData, 32'h44332211);
        check("mis_excCode", excCode, 0);
`else
        issue(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 4'd6);
        check("mis_busValid", busValid, 0);
        check("mis_rspValid", rspValid, 1);
        check("mis_excCode", excCode, 2);
        check("mis_rspData", rspData, 0);
        check("mis_reqReady", reqReady, 1);
        step();
        check("mis_rsp_pulse", rspValid, 0);
`endif

        // Illegal size is a usage fault in every build
        issue(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 4'd2);
        check("ill_busValid", busValid, 0);
        check("ill_rspValid", rspValid, 1);
        check("ill_excCode", excCode, 2);
        step();

        // 5a: no ack -> timeout after 16 cycles of busValid
        issue(1'b0, 2'b00, 1'b0, 32'h200, 32'h0, 4'd8);
        for (int i = 0; i < 15; i++) step();
        check("to_busValid_16", busValid, 1);
        check("to_rspValid_16", rspValid, 0);
        step();
        check("to_busValid_drop", busValid, 0);
        check("to_rspValid", rspValid, 1);
        check("to_excCode", excCode, 1);
        check("to_rspData", rspData, 0);

        // 5b: busErr and busAck together -> bus fault
        issue(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 4'd9);
        busErr = 1'b1;
        ackBeat(32'h12345678);
        busErr = 1'b0;
        check("err_rspValid", rspValid, 1);
        check("err_excCode", excCode, 1);
        check("err_rspData", rspData, 0);
        check("err_busValid", busValid, 0);

        // 6: reset mid-transaction
        issue(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 4'd1);
        check("mrst_busValid_pre", busValid, 1);
        resetN = 1'b0;
        step();
        check("mrst_busValid", busValid, 0);
        check("mrst_reqReady", reqReady, 1);
        check("mrst_rspValid", rspValid, 0);
        resetN = 1'b1;
        step();
        check("mrst_rspValid_after", rspValid, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
